ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
// - PS/2 keyboard receiver and scan-code decoder for the hex-entry front end.
// - Deserialises PS/2 device-to-host frames and decodes scan-code set 2 make codes into
//   hex digits, Enter and two control keys.
// - Emits each decoded key as a one-cycle event (R_O + out + flags) to the system-level
//   input controller.
// PARAMETERS
// - TIMEOUT_CYCLES   default 100000 : clk cycles with no PS2_clk falling edge before a
//                                     partial frame is dropped (1 ms at 100 MHz).
// PORTS
// - clk      in   1  system clock; all logic is on its rising edge.
// - RESET    in   1  asynchronous, active-high reset.
// - PS2_clk  in   1  PS/2 clock from keyboard (asynchronous, open-collector, idle high).
// - PS2_dat  in   1  PS/2 data from keyboard (asynchronous, idle high).
// - R_O      out  1  key-event strobe; high for exactly one clk cycle per decoded key.
// - out      out  5  key code; valid while R_O=1, held until the next event.
// - flags    out  3  key class: 001 = hex digit, 010 = Enter, 100 = control key.
// BEHAVIOUR
// - Reset state: R_O=0, out=5'd0, flags=3'd0; receiver idle, bit counter 0, break/extended
//   prefix flags cleared, timeout counter 0.
// - Input sync and edge detect:
//   - PS2_clk and PS2_dat each pass through 2-FF synchronisers.
//   - A PS2_clk falling edge is detected from the synchronised clock: previous=1, current=0.
//   - Data is sampled on that edge.
// - Frame format: 11 bits, LSB first: start (0), d0..d7, odd parity, stop (1).
//   - The bit counter runs 0..10.
//   - Start bit sampled as 1: ignore it, stay idle, counter stays 0.
// - Timeout:
//   - The counter increments every clk while a frame is in progress and clears on each
//     falling edge.
//   - When it reaches TIMEOUT_CYCLES, the partial frame is discarded and the bit counter
//     returns to 0.
//   - Prefix flags are kept.
// - Frame check at stop bit:
//   - Odd-parity error or stop bit = 0: discard the byte and clear both prefix flags.
//     No event.
// - Byte handling for a valid byte B:
//   - B=F0: set break flag, no event.
//   - B=E0: set extended flag, no event.
//   - Otherwise, if the break flag is set: no event, clear both flags (key release).
//   - Otherwise decode B, emit the event if B is in the table, and clear both flags.
// - Decode table:
//   - flags=001, out={0,nibble}, main row: 45=0 16=1 1E=2 26=3 25=4 2E=5 36=6 3D=7 3E=8
//     46=9 1C=A 32=B 21=C 23=D 24=E 2B=F.
//   - flags=001, keypad: 70=0 69=1 72=2 7A=3 6B=4 73=5 74=6 6C=7 75=8 7D=9.
//   - Keypad digits are decoded only when the extended flag is clear.
//   - flags=010, out=00000: 5A, with or without E0 (main and keypad Enter).
//   - flags=100, out=10000: 29 (Space = "next").
//   - flags=100, out=10001: 76 (Esc = "clear/reset").
//   - Any other code: no event, flags cleared.
// - Event timing:
//   - R_O rises on the clk edge after the one where the stop bit is sampled, and falls
//     on the following edge.
//   - out and flags update on the same edge R_O rises, then hold.
// - Event spacing: events cannot be back-to-back; the minimum spacing is one PS/2 frame.
// - RESET mid-frame: abort immediately to the reset state. No event is emitted for the
//   partial frame.
// TESTING
// - Frame 0x16 with good parity -> one R_O pulse, out=00001, flags=001; R_O low the next cycle.
// - Frames F0,16 (release) -> no R_O pulse; a following 0x1C -> out=01010, flags=001.
// - Frames 5A, then E0,5A -> two pulses, each out=00000, flags=010.
// - Frame 0x29 -> out=10000, flags=100; frame 0x76 -> out=10001, flags=100.
// - Frame 0x16 with the parity bit flipped -> no pulse; a following valid 0x45 -> out=00000,
//   flags=001.
// - 5 bits of a frame, then idle > TIMEOUT_CYCLES, then full 0x2B -> exactly one pulse,
//   out=01111; RESET asserted mid-frame -> outputs 0, no pulse.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scan-code set 2 decoder.
// Deserialises device-to-host frames and turns make codes for hex digits,
// Enter, Space and Esc into one-cycle key events (R_O + out + flags).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a start bit (0) on a PS2_clk falling edge
// S_RECV  | frame in progress; bit_cnt_q counts bits 1..10, timeout runs
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       PS2_clk,
  input  logic       PS2_dat,
  output logic       R_O,
  output logic [4:0] out,
  output logic [2:0] flags
);

  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES);

  typedef enum logic {S_IDLE, S_RECV} state_e;

  // decoded result: {hit, flags[2:0], out[4:0]}
  function automatic logic [8:0] decode(input logic [7:0] code, input logic ext);
    logic [8:0] r;
    r = 9'd0;
    case (code)
      8'h45: r = {1'b1, 3'b001, 5'h00};
      8'h16: r = {1'b1, 3'b001, 5'h01};
      8'h1E: r = {1'b1, 3'b001, 5'h02};
      8'h26: r = {1'b1, 3'b001, 5'h03};
      8'h25: r = {1'b1, 3'b001, 5'h04};
      8'h2E: r = {1'b1, 3'b001, 5'h05};
      8'h36: r = {1'b1, 3'b001, 5'h06};
      8'h3D: r = {1'b1, 3'b001, 5'h07};
      8'h3E: r = {1'b1, 3'b001, 5'h08};
      8'h46: r = {1'b1, 3'b001, 5'h09};
      8'h1C: r = {1'b1, 3'b001, 5'h0A};
      8'h32: r = {1'b1, 3'b001, 5'h0B};
      8'h21: r = {1'b1, 3'b001, 5'h0C};
      8'h23: r = {1'b1, 3'b001, 5'h0D};
      8'h24: r = {1'b1, 3'b001, 5'h0E};
      8'h2B: r = {1'b1, 3'b001, 5'h0F};
      // keypad digits share codes with navigation keys behind E0
      8'h70: r = ext ? 9'd0 : {1'b1, 3'b001, 5'h00};
      8'h69: r = ext ? 9'd0 : {1'b1, 3'b001, 5'h01};
      8'h72: r = ext ? 9'd0 : {1'b1, 3'b001, 5'h02};
      8'h7A: r = ext ? 9'd0 : {1'b1, 3'b001, 5'h03};
      8'h6B: r = ext ? 9'd0 : {1'b1, 3'b001, 5'h04};
      8'h73: r = ext ? 9'd0 : {1'b1, 3'b001, 5'h05};
      8'h74: r = ext ? 9'd0 : {1'b1, 3'b001, 5'h06};
      8'h6C: r = ext ? 9'd0 : {1'b1, 3'b001, 5'h07};
      8'h75: r = ext ? 9'd0 : {1'b1, 3'b001, 5'h08};
      8'h7D: r = ext ? 9'd0 : {1'b1, 3'b001, 5'h09};
      8'h5A: r = {1'b1, 3'b010, 5'h00};
      8'h29: r = {1'b1, 3'b100, 5'h10};
      8'h76: r = {1'b1, 3'b100, 5'h11};
      default: r = 9'd0;
    endcase
    return r;
  endfunction

  logic          clk_meta_q, clk_sync_q, clk_prev_q;
  logic          dat_meta_q, dat_sync_q;
  logic          fall;

  state_e        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic          pend_q, pend_d;
  logic [4:0]    pend_out_q, pend_out_d;
  logic [2:0]    pend_flags_q, pend_flags_d;
  logic          ro_q, ro_d;
  logic [4:0]    out_q, out_d;
  logic [2:0]    flags_q, flags_d;
  logic [8:0]    dec;

  // two-flop synchronisers; reset to the idle-high line level so reset
  // release never looks like a falling edge
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= PS2_clk;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= PS2_dat;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q;
  assign dec  = decode(shift_q[7:0], ext_q);

  // receiver, prefix tracking and event generation
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    to_cnt_d     = to_cnt_q;
    brk_d        = brk_q;
    ext_d        = ext_q;
    pend_d       = 1'b0;
    pend_out_d   = pend_out_q;
    pend_flags_d = pend_flags_q;
    ro_d         = pend_q;
    out_d        = out_q;
    flags_d      = flags_q;

    if (pend_q) begin
      out_d   = pend_out_q;
      flags_d = pend_flags_q;
    end

    case (state_q)
      S_IDLE: begin
        to_cnt_d  = '0;
        bit_cnt_d = 4'd0;
        if (fall && !dat_sync_q) begin
          state_d   = S_RECV;
          bit_cnt_d = 4'd1;
        end
      end
      S_RECV: begin
        if (fall) begin
          to_cnt_d = '0;
          if (bit_cnt_q == 4'd10) begin
            state_d   = S_IDLE;
            bit_cnt_d = 4'd0;
            // shift_q holds d0..d7 plus parity: the 9 bits must have odd weight
            if (!dat_sync_q || !(^shift_q)) begin
              brk_d = 1'b0;
              ext_d = 1'b0;
            end else if (shift_q[7:0] == 8'hF0) begin
              brk_d = 1'b1;
            end else if (shift_q[7:0] == 8'hE0) begin
              ext_d = 1'b1;
            end else begin
              brk_d = 1'b0;
              ext_d = 1'b0;
              if (!brk_q && dec[8]) begin
                pend_d       = 1'b1;
                pend_flags_d = dec[7:5];
                pend_out_d   = dec[4:0];
              end
            end
          end else begin
            shift_d   = {dat_sync_q, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          // stalled frame: drop it but keep any F0/E0 prefix already seen
          state_d   = S_IDLE;
          bit_cnt_d = 4'd0;
          to_cnt_d  = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = 4'd0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 9'd0;
      to_cnt_q     <= '0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      pend_q       <= 1'b0;
      pend_out_q   <= 5'd0;
      pend_flags_q <= 3'd0;
      ro_q         <= 1'b0;
      out_q        <= 5'd0;
      flags_q      <= 3'd0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      to_cnt_q     <= to_cnt_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      pend_q       <= pend_d;
      pend_out_q   <= pend_out_d;
      pend_flags_q <= pend_flags_d;
      ro_q         <= ro_d;
      out_q        <= out_d;
      flags_q      <= flags_d;
    end
  end

  assign R_O   = ro_q;
  assign out   = out_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: PS/2 frames are bit-banged onto the inputs,
// expected key events are queued as frames are sent and matched as R_O pulses.
module tb_ps2_key_decoder;

  localparam int TO   = 300;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       PS2_clk = 1'b1;
  logic       PS2_dat = 1'b1;
  logic       R_O;
  logic [4:0] out;
  logic [2:0] flags;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] sb_q[$];

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .RESET(RESET), .PS2_clk(PS2_clk), .PS2_dat(PS2_dat),
    .R_O(R_O), .out(out), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // drive the first nbits of a frame, LSB first
  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      PS2_dat = bits[i];
      idle(HALF);
      PS2_clk = 1'b0;
      idle(HALF);
      PS2_clk = 1'b1;
    end
    idle(HALF);
    PS2_dat = 1'b1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    send_bits(frame(b), 11);
  endtask

  task automatic expect_key(input logic [7:0] b, input logic [4:0] o, input logic [2:0] f);
    sb_q.push_back({o, f});
    send_byte(b);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb_q.size(), 0);
  endtask

  // event monitor: every R_O pulse must match the oldest queued expectation
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (R_O === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_event", {out, flags}, 32'h1FF);
        end else begin
          e = sb_q.pop_front();
          chk("event_code", {out, flags}, e);
        end
        @(negedge clk);
        chk("ro_one_cycle", R_O, 0);
      end
    end
  end

  initial begin
    logic [10:0] fr;
    idle(3);
    chk("rst_ro", R_O, 0);
    chk("rst_out", out, 0);
    chk("rst_flags", flags, 0);
    RESET = 1'b0;
    idle(5);

    expect_key(8'h16, 5'h01, 3'b001);
    wait_drain();

    send_byte(8'hF0);
    send_byte(8'h16);
    idle(20);
    expect_key(8'h1C, 5'h0A, 3'b001);
    wait_drain();

    expect_key(8'h5A, 5'h00, 3'b010);
    wait_drain();
    send_byte(8'hE0);
    expect_key(8'h5A, 5'h00, 3'b010);
    wait_drain();

    expect_key(8'h29, 5'h10, 3'b100);
    wait_drain();
    expect_key(8'h76, 5'h11, 3'b100);
    wait_drain();

    fr = frame(8'h16);
    fr[9] = ~fr[9];
    send_bits(fr, 11);
    idle(20);
    expect_key(8'h45, 5'h00, 3'b001);
    wait_drain();

    fr = frame(8'h16);
    fr[10] = 1'b0;
    send_bits(fr, 11);
    idle(20);
    expect_key(8'h3D, 5'h07, 3'b001);
    wait_drain();

    expect_key(8'h70, 5'h00, 3'b001);
    wait_drain();
    send_byte(8'hE0);
    send_byte(8'h70);
    send_byte(8'h1A);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h5A);
    idle(20);
    expect_key(8'h7D, 5'h09, 3'b001);
    wait_drain();

    // a stalled partial frame is dropped and the next frame decodes cleanly
    send_bits(frame(8'h2B), 5);
    idle(TO + 100);
    expect_key(8'h2B, 5'h0F, 3'b001);
    wait_drain();

    // reset in the middle of a frame
    send_bits(frame(8'h16), 5);
    RESET = 1'b1;
    idle(2);
    chk("midrst_ro", R_O, 0);
    chk("midrst_out", out, 0);
    chk("midrst_flags", flags, 0);
    RESET = 1'b0;
    idle(TO + 50);
    expect_key(8'h76, 5'h11, 3'b100);
    wait_drain();

    idle(50);
    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
